// File: rtl/bias_accum_buf.sv
// Bias-gradient accumulation buffer: per-address signed running sums, RMW pipeline with forwarding, drain read port.
// Define BBUF_ACC_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module bias_accum_buf #(
   parameter int BUF_DEPTH = 256,
   parameter int ADDR_W    = $clog2(BUF_DEPTH),
   parameter int RES_W     = 32,
   parameter int ACC_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   output logic              busy,
   input  logic              accum_en,
   input  logic              accum_new,
   input  logic [ADDR_W-1:0] accum_addr,
   input  logic [RES_W-1:0]  accum_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic [ACC_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic              drop_err
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;

   // S1 stage: request registered in the accept cycle, RAM data arrives alongside it
   logic                    s1_valid, s1_new;
   logic [ADDR_W-1:0]       s1_addr;
   logic signed [RES_W-1:0] s1_data;

   // S2 stage: result written last cycle, kept for forwarding into a same-address S1
   logic                    s2_valid;
   logic [ADDR_W-1:0]       s2_addr;
   logic [ACC_W-1:0]        s2_sum;

   logic [ACC_W-1:0]        mem [BUF_DEPTH];
   logic [ACC_W-1:0]        ram_q;
   logic [ACC_W-1:0]        rd_hold;
   logic [ADDR_W-1:0]       raddr;

   logic                    run, accept, rd_take, sweep_we, fwd_hit;
   logic signed [ACC_W-1:0] old_val, add_val, sum;

   assign run      = (state == RUN);
   assign busy     = (state == CLEAR);
   assign sweep_we = (state == CLEAR);
   assign accept   = accum_en && run && !clear;
   assign rd_ready = run && !accum_en && !s1_valid && !s2_valid;
   assign rd_take  = rd_en && rd_ready;
   assign raddr    = accept ? accum_addr : rd_addr;
   assign fwd_hit  = s2_valid && (s2_addr == s1_addr);
   assign rd_data  = rd_valid ? ram_q : rd_hold;

   // NOTE: every variable an always_comb writes gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      case (state)
         IDLE: begin
            if (clear) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
            end
         end
         CLEAR: begin
            if (clear) begin
               clr_addr_nxt = '0;
            end else if (clr_addr == ADDR_W'(BUF_DEPTH - 1)) begin
               state_nxt = RUN;
            end else begin
               clr_addr_nxt = clr_addr + 1'b1;
            end
         end
         RUN: begin
            if (clear) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      old_val = s1_new ? '0 : (fwd_hit ? s2_sum : ram_q);
      add_val = ACC_W'(s1_data);
`ifdef BBUF_ACC_SAT_EN
      begin
         logic [ACC_W:0] wide;
         wide = {old_val[ACC_W-1], old_val} + {add_val[ACC_W-1], add_val};
         if (wide[ACC_W] != wide[ACC_W-1]) begin
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            sum = wide[ACC_W-1:0];
         end
      end
`else
      sum = old_val + add_val;
`endif
   end

   // NOTE: non-blocking assignments for all state, so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         clr_addr <= '0;
         s1_valid <= 1'b0;
         s1_new   <= 1'b0;
         s1_addr  <= '0;
         s1_data  <= '0;
         s2_valid <= 1'b0;
         s2_addr  <= '0;
         s2_sum   <= '0;
         rd_valid <= 1'b0;
         rd_hold  <= '0;
         drop_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         s1_valid <= accept;
         if (accept) begin
            s1_new  <= accum_new;
            s1_addr <= accum_addr;
            s1_data <= accum_data;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_addr <= s1_addr;
            s2_sum  <= sum;
         end
         rd_valid <= rd_take;
         if (rd_valid) begin
            rd_hold <= ram_q;
         end
         if (accum_en && !accept) begin
            drop_err <= 1'b1;
         end
      end
   end

   // NOTE: the array has no reset; its contents are defined by the clear sweep, which keeps it mappable to block RAM.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[clr_addr] <= '0;
      end else if (s1_valid) begin
         mem[s1_addr] <= sum;
      end
      ram_q <= mem[raddr];
   end

endmodule

// File: tb/tb_bias_accum_buf.sv
// Directed self-checking bench for bias_accum_buf: a 256x32 instance plus a 16x8 instance for overflow behaviour.
module tb_bias_accum_buf;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clear, busy;
   logic        accum_en, accum_new;
   logic [7:0]  accum_addr;
   logic [31:0] accum_data;
   logic        rd_en, rd_ready, rd_valid, drop_err;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;

   logic        s_clear, s_busy, s_accum_en, s_accum_new;
   logic [3:0]  s_accum_addr, s_rd_addr;
   logic [7:0]  s_accum_data, s_rd_data;
   logic        s_rd_en, s_rd_ready, s_rd_valid, s_drop_err;

   int n_checks = 0;
   int n_errors = 0;
   int busy_cnt;

   bias_accum_buf #(.BUF_DEPTH(256), .RES_W(32), .ACC_W(32)) dut (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy),
      .accum_en(accum_en), .accum_new(accum_new), .accum_addr(accum_addr), .accum_data(accum_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_valid(rd_valid), .drop_err(drop_err)
   );

   bias_accum_buf #(.BUF_DEPTH(16), .RES_W(8), .ACC_W(8)) dut_small (
      .clk(clk), .rst(rst), .clear(s_clear), .busy(s_busy),
      .accum_en(s_accum_en), .accum_new(s_accum_new), .accum_addr(s_accum_addr), .accum_data(s_accum_data),
      .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_ready(s_rd_ready), .rd_data(s_rd_data),
      .rd_valid(s_rd_valid), .drop_err(s_drop_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; leaves the request on the inputs for the following posedge.
   task automatic accum(input logic nw, input logic [7:0] a, input logic [31:0] d);
      accum_en   = 1'b1;
      accum_new  = nw;
      accum_addr = a;
      accum_data = d;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
      int n;
      n = 0;
      rd_en   = 1'b1;
      rd_addr = a;
      #1;
      while (!rd_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_ready"}, 32'(rd_ready), 32'd1);
      @(negedge clk);
      rd_en = 1'b0;
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, rd_data, exp);
      @(negedge clk);
      check({tag, "_valid_drop"}, 32'(rd_valid), 32'd0);
      check({tag, "_hold"}, rd_data, exp);
   endtask

   task automatic count_busy(input string tag);
      busy_cnt = 0;
      while (busy && busy_cnt < 1000) begin
         busy_cnt++;
         @(negedge clk);
      end
      check(tag, busy_cnt, 32'd256);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; accum_en = 1'b0; accum_new = 1'b0; accum_addr = '0; accum_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      s_clear = 1'b0; s_accum_en = 1'b0; s_accum_new = 1'b0; s_accum_addr = '0; s_accum_data = '0;
      s_rd_en = 1'b0; s_rd_addr = '0;
      #2 rst = 1'b0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_ready", 32'(rd_ready), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_drop_err", 32'(drop_err), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Initial clear sweep on both instances
      clear = 1'b1; s_clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; s_clear = 1'b0;
      count_busy("sweep_len");
      check("run_rd_ready", 32'(rd_ready), 32'd1);
      for (int i = 0; i < 256; i++) do_read(8'(i), 32'd0, "sweep_zero");

      // Same address back to back exercises the forwarding path
      accum(1'b1, 8'd5, 32'd10);
      accum(1'b0, 8'd5, -32'sd3);
      accum_en = 1'b0;
      do_read(8'd5, 32'd7, "fwd_addr5");

      // Interleaved addresses: the third request must see the first through RAM
      accum(1'b1, 8'd3, 32'd100);
      accum(1'b1, 8'd4, 32'd1);
      accum(1'b0, 8'd3, -32'sd100);
      accum_en = 1'b0;
      do_read(8'd3, 32'd0, "interleave_addr3");
      do_read(8'd4, 32'd1, "interleave_addr4");

      // Signed overflow at full width
      accum(1'b1, 8'd7, 32'h7FFF_FFFF);
      accum(1'b0, 8'd7, 32'd1);
      accum_en = 1'b0;
`ifdef BBUF_ACC_SAT_EN
      do_read(8'd7, 32'h7FFF_FFFF, "ovf_addr7");
`else
      do_read(8'd7, 32'h8000_0000, "ovf_addr7");
`endif

      // Read held while four accumulations stream in
      rd_en = 1'b1; rd_addr = 8'd10;
      for (int i = 0; i < 4; i++) begin
         accum_en = 1'b1; accum_new = (i == 0); accum_addr = 8'd10; accum_data = 32'(i + 1);
         #1;
         check("blk_ready_during", 32'(rd_ready), 32'd0);
         @(negedge clk);
      end
      accum_en = 1'b0; accum_new = 1'b0;
      #1;
      check("blk_ready_after1", 32'(rd_ready), 32'd0);
      check("blk_valid_after1", 32'(rd_valid), 32'd0);
      @(negedge clk); #1;
      check("blk_ready_after2", 32'(rd_ready), 32'd0);
      @(negedge clk); #1;
      check("blk_ready_free", 32'(rd_ready), 32'd1);
      @(negedge clk);
      rd_en = 1'b0;
      check("blk_valid", 32'(rd_valid), 32'd1);
      check("blk_data", rd_data, 32'd10);
      check("no_drop_yet", 32'(drop_err), 32'd0);

      // Accumulation during a sweep is dropped; a second clear restarts the sweep
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear2_busy", 32'(busy), 32'd1);
      accum(1'b1, 8'd9, 32'd50);
      accum_en = 1'b0;
      check("drop_set", 32'(drop_err), 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      count_busy("restart_sweep_len");
      do_read(8'd9, 32'd0, "dropped_addr9");
      do_read(8'd5, 32'd0, "recleared_addr5");
      check("drop_sticky", 32'(drop_err), 32'd1);

      // Narrow instance: positive and negative overflow
      s_accum_en = 1'b1; s_accum_new = 1'b1; s_accum_addr = 4'd0; s_accum_data = 8'd127;
      @(negedge clk);
      s_accum_new = 1'b0; s_accum_data = 8'd1;
      @(negedge clk);
      s_accum_new = 1'b1; s_accum_addr = 4'd1; s_accum_data = 8'h80;
      @(negedge clk);
      s_accum_new = 1'b0; s_accum_data = 8'hFF;
      @(negedge clk);
      s_accum_en = 1'b0;
      repeat (2) @(negedge clk);
      s_rd_en = 1'b1; s_rd_addr = 4'd0;
      #1;
      check("small_ready0", 32'(s_rd_ready), 32'd1);
      @(negedge clk);
      s_rd_addr = 4'd1;
      check("small_valid0", 32'(s_rd_valid), 32'd1);
`ifdef BBUF_ACC_SAT_EN
      check("small_pos_ovf", 32'(s_rd_data), 32'h7F);
`else
      check("small_pos_ovf", 32'(s_rd_data), 32'h80);
`endif
      @(negedge clk);
      s_rd_en = 1'b0;
      check("small_valid1", 32'(s_rd_valid), 32'd1);
`ifdef BBUF_ACC_SAT_EN
      check("small_neg_ovf", 32'(s_rd_data), 32'h80);
`else
      check("small_neg_ovf", 32'(s_rd_data), 32'h7F);
`endif
      check("small_drop_err", 32'(s_drop_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
